video_timing_gen: RTL

Raster timing controller that sequences the HDMI test-pattern datapath. It runs horizontal and vertical counters at the pixel rate and drives `pixel_x`, `pixel_y` and `active` straight into the colour-bar generator. It also drives sync and frame/line strobes toward the TMDS encoder side. All geometry is set by parameters; the defaults are 640x480@60 (800x525 total).

---
 rtl/video_timing_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing controller for the HDMI test-pattern datapath. Horizontal and
// vertical counters advance at the pixel rate (gated by pix_en). Every output
// is decoded straight from those counter registers, so pixel_x/pixel_y,
// active and the syncs carry no relative skew. Geometry is fully
// parameterised; the defaults give 640x480@60 (800x525 total).
//
// Ports
//   clk          in   1   pixel-domain clock
//   rst          in   1   synchronous active-high reset
//   pix_en       in   1   pixel clock enable; counters move only when high
//   pixel_x      out  10  horizontal counter, 0..H_TOTAL-1 (raw, incl. blanking)
//   pixel_y      out  10  vertical counter, 0..V_TOTAL-1
//   active       out  1   visible-area flag
//   hsync        out  1   horizontal sync, asserted level HSYNC_POL
//   vsync        out  1   vertical sync, asserted level VSYNC_POL
//   line_start   out  1   one-clock strobe at h_cnt==0 on an enabled cycle
//   frame_start  out  1   one-clock strobe at (0,0) on an enabled cycle
//   frame_count  out  16  index of the current frame (wraps mod 2^16)
// -----------------------------------------------------------------------------
module video_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        active,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Counters are 10 bits wide, so a larger raster cannot be represented.
   if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_geometry_check
      $error("video_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d outside 1..1024", H_TOTAL, V_TOTAL);
   end

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   // Decode boundaries are one bit wider than the counters so that a region
   // ending exactly at 1024 still compares correctly.
   localparam logic [10:0] H_ACT_END   = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FRONT);
   localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_ACT_END   = 11'(V_ACTIVE);
   localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FRONT);
   localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [15:0] frame_cnt;
   logic [10:0] h_ext;
   logic [10:0] v_ext;
   logic        in_hsync;
   logic        in_vsync;

   // Reset parks the raster on its final blanking pixel with frame_cnt at
   // all-ones, so the first enabled edge lands on (0,0) and frame 0.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours; blocking here would let
   // v_cnt see an already-wrapped h_cnt and break the simultaneous wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt     <= H_LAST;
         v_cnt     <= V_LAST;
         frame_cnt <= 16'hFFFF;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            if (v_cnt == V_LAST) begin
               v_cnt     <= 10'd0;
               frame_cnt <= frame_cnt + 16'd1;
            end else begin
               v_cnt <= v_cnt + 10'd1;
            end
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   assign h_ext = {1'b0, h_cnt};
   assign v_ext = {1'b0, v_cnt};

   assign in_hsync = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
   assign in_vsync = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

   assign pixel_x     = h_cnt;
   assign pixel_y     = v_cnt;
   assign frame_count = frame_cnt;
   assign active      = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
   assign hsync       = in_hsync ? HSYNC_POL : ~HSYNC_POL;
   assign vsync       = in_vsync ? VSYNC_POL : ~VSYNC_POL;

   // Strobes are masked by rst: in the first reset cycle the counters can
   // still sit at h_cnt==0, and the encoder must not see a line/frame start
   // for a raster that is about to be discarded.
   assign line_start  = pix_en && !rst && (h_cnt == 10'd0);
   assign frame_start = line_start && (v_cnt == 10'd0);

endmodule
